// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch unit with
// IF/ID output register, redirect flush and response drop.
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic        pc_en_o,
  input  logic        flush_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_exc_o
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] req_pc_q;

  logic slot_free;
  logic aligned;
  logic issue;
  logic grant;
  logic misal;
  logic load_rsp;

  always_comb begin
    slot_free   = !if_valid_o || !stall_i;
    aligned     = (pc_i[1:0] == 2'b00);
    issue       = !rst && (state_q == S_REQ)
                  && slot_free && !flush_i;
    imem_req_o  = issue && aligned;
    imem_addr_o = pc_i;
    grant       = imem_req_o && imem_gnt_i;
    // misaligned PC retires as an exception without touching memory
    misal       = issue && !aligned;
    pc_en_o     = grant || misal;
    load_rsp    = (state_q == S_WAIT)
                  && imem_rvalid_i && !flush_i;

    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (grant)
          state_d = flush_i ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i)
          state_d = S_REQ;
        else if (flush_i)
          state_d = S_DROP;
      end
      S_DROP: begin
        if (imem_rvalid_i)
          state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant)
        req_pc_q <= pc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_o <= 1'b0;
      if_exc_o   <= 1'b0;
      if_pc_o    <= '0;
      if_inst_o  <= '0;
    end else if (flush_i) begin
      if_valid_o <= 1'b0;
      if_exc_o   <= 1'b0;
    end else if (load_rsp) begin
      if_valid_o <= 1'b1;
      if_exc_o   <= 1'b0;
      if_pc_o    <= req_pc_q;
      if_inst_o  <= imem_rdata_i;
    end else if (misal) begin
      if_valid_o <= 1'b1;
      if_exc_o   <= 1'b1;
      if_pc_o    <= pc_i;
      if_inst_o  <= '0;
    end else if (if_valid_o && !stall_i) begin
      if_valid_o <= 1'b0;
      if_exc_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed plus randomized checks of inst_fetch
// against a transaction-level fetch/memory model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_en_o;
  logic        flush_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_exc_o;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .pc_en_o      (pc_en_o),
    .flush_i      (flush_i),
    .stall_i      (stall_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .if_valid_o   (if_valid_o),
    .if_pc_o      (if_pc_o),
    .if_inst_o    (if_inst_o),
    .if_exc_o     (if_exc_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // memory model
  bit          mem_pend = 0;
  int          mem_dly  = 0;
  logic [31:0] mem_word = '0;

  // fetch model: outstanding/discard bookkeeping plus IF/ID contents
  bit          m_busy    = 0;
  bit          m_discard = 0;
  bit          m_valid   = 0;
  bit          m_exc     = 0;
  logic [31:0] m_pc      = '0;
  logic [31:0] m_inst    = '0;
  logic [31:0] m_req_pc  = '0;
  bit          saw_pcen  = 0;

  function automatic logic [31:0] word_for(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h24080001;
    if (a == 32'hBFC0000C) return 32'hDEADBEEF;
    return a ^ 32'h5A5A0F0F;
  endfunction

  task automatic cycle(input logic r, input logic f,
                       input logic s, input logic g,
                       input int dly);
    bit al, fr, iss, e_req, e_pcen, rsp;
    bit n_busy, n_disc, n_valid, n_exc;
    logic [31:0] n_pc, n_inst, n_rpc;
    @(negedge clk);
    rst           = r;
    flush_i       = f;
    stall_i       = s;
    imem_gnt_i    = g;
    imem_rvalid_i = mem_pend && (mem_dly == 0);
    imem_rdata_i  = imem_rvalid_i ? mem_word : $urandom;
    #1;
    al     = (pc_i[1:0] == 2'b00);
    fr     = !m_valid || !s;
    iss    = !r && !m_busy && fr && !f;
    e_req  = iss && al;
    e_pcen = (e_req && g) || (iss && !al);
    check("req", 32'(imem_req_o), 32'(e_req));
    check("pc_en", 32'(pc_en_o), 32'(e_pcen));
    if (e_req) check("addr", imem_addr_o, pc_i);
    saw_pcen = pc_en_o;

    if (imem_rvalid_i) mem_pend = 0;
    else if (mem_pend) mem_dly--;
    if (imem_req_o && g && !r) begin
      mem_pend = 1;
      mem_word = word_for(imem_addr_o);
      mem_dly  = (dly < 0) ? int'($urandom_range(0, 2)) : dly;
    end

    n_busy = m_busy; n_disc = m_discard; n_valid = m_valid;
    n_exc = m_exc; n_pc = m_pc; n_inst = m_inst; n_rpc = m_req_pc;
    if (r) begin
      n_busy = 0; n_disc = 0; n_valid = 0; n_exc = 0;
      n_pc = '0; n_inst = '0; n_rpc = '0;
    end else begin
      rsp = m_busy && imem_rvalid_i;
      if (rsp) begin
        n_busy = 0;
        n_disc = 0;
      end else if (f && m_busy) begin
        n_disc = 1;
      end
      if (e_req && g) begin
        n_busy = 1; n_disc = 0; n_rpc = pc_i;
      end
      if (f) begin
        n_valid = 0; n_exc = 0;
      end else if (rsp && !m_discard) begin
        n_valid = 1; n_exc = 0;
        n_pc = m_req_pc; n_inst = imem_rdata_i;
      end else if (iss && !al) begin
        n_valid = 1; n_exc = 1; n_pc = pc_i; n_inst = '0;
      end else if (m_valid && !s) begin
        n_valid = 0; n_exc = 0;
      end
    end

    @(posedge clk);
    #1;
    m_busy = n_busy; m_discard = n_disc; m_valid = n_valid;
    m_exc = n_exc; m_pc = n_pc; m_inst = n_inst; m_req_pc = n_rpc;
    check("valid", 32'(if_valid_o), 32'(m_valid));
    if (m_valid) begin
      check("if_pc", if_pc_o, m_pc);
      check("if_inst", if_inst_o, m_inst);
      check("if_exc", 32'(if_exc_o), 32'(m_exc));
    end
  endtask

  logic [31:0] tmp;
  logic        rf, rs, rg;

  initial begin
    rst = 1'b1; flush_i = 0; stall_i = 0; imem_gnt_i = 0;
    imem_rvalid_i = 0; imem_rdata_i = '0;
    pc_i = 32'hBFC00000;

    // reset state
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("rst_valid", 32'(if_valid_o), 32'd0);
    check("rst_exc", 32'(if_exc_o), 32'd0);
    check("rst_pc", if_pc_o, 32'd0);
    check("rst_inst", if_inst_o, 32'd0);

    // boot fetch, zero-wait memory
    cycle(0, 0, 0, 1, 0);
    pc_i = 32'hBFC00004;
    cycle(0, 0, 1, 0, 0);
    check("boot_valid", 32'(if_valid_o), 32'd1);
    check("boot_pc", if_pc_o, 32'hBFC00000);
    check("boot_inst", if_inst_o, 32'h24080001);

    // stall holds the slot and blocks new requests
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 1, 0);
      check("stall_inst", if_inst_o, 32'h24080001);
    end
    cycle(0, 0, 0, 1, 0);
    pc_i = 32'hBFC00008;
    cycle(0, 0, 0, 0, 0);

    // grant withheld for three cycles
    repeat (3) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    pc_i = 32'hBFC0000C;
    cycle(0, 0, 0, 0, 0);

    // flush while waiting; late response must be dropped
    cycle(0, 0, 0, 1, 2);
    pc_i = 32'hBFC00010;
    cycle(0, 1, 0, 0, 0);
    pc_i = 32'hBFC00100;
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check("drop_valid", 32'(if_valid_o), 32'd0);
    cycle(0, 0, 0, 1, 0);
    pc_i = 32'hBFC00104;
    cycle(0, 0, 0, 0, 0);
    check("after_drop_pc", if_pc_o, 32'hBFC00100);

    // misaligned fetch raises an exception without a request
    pc_i = 32'hBFC00002;
    cycle(0, 0, 0, 1, 0);
    check("mis_valid", 32'(if_valid_o), 32'd1);
    check("mis_exc", 32'(if_exc_o), 32'd1);
    check("mis_pc", if_pc_o, 32'hBFC00002);
    check("mis_inst", if_inst_o, 32'd0);
    cycle(0, 1, 1, 0, 0);
    check("flush_valid", 32'(if_valid_o), 32'd0);
    check("flush_exc", 32'(if_exc_o), 32'd0);

    // reset during an outstanding request; stale response ignored
    pc_i = 32'hBFC00004;
    cycle(0, 0, 0, 1, 0);
    pc_i = 32'hBFC00000;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("rst_mid_valid", 32'(if_valid_o), 32'd0);
    cycle(0, 0, 0, 1, 0);
    pc_i = 32'hBFC00004;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        repeat (3) begin
          rf = 1'($urandom_range(0, 1));
          rs = 1'($urandom_range(0, 1));
          rg = 1'($urandom_range(0, 1));
          cycle(1, rf, rs, rg, -1);
        end
        pc_i = 32'hBFC00000;
      end else begin
        rf = ($urandom_range(0, 11) == 0);
        rs = ($urandom_range(0, 2) == 0);
        rg = 1'($urandom_range(0, 1));
        cycle(0, rf, rs, rg, -1);
        if (rf) begin
          tmp = $urandom;
          if ($urandom_range(0, 5) == 0)
            pc_i = {tmp[31:2], 2'b10};
          else
            pc_i = {tmp[31:2], 2'b00};
        end else if (saw_pcen) begin
          if (pc_i[1:0] != 2'b00)
            pc_i = {pc_i[31:2], 2'b00} + 32'd4;
          else if ($urandom_range(0, 15) == 0)
            pc_i = pc_i + 32'd2;
          else
            pc_i = pc_i + 32'd4;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: pc_i  input  32  current fetch PC from the PC register.
REQ-004 SHALL have port: pc_en_o  output  1  advance enable to the PC register (drives its en).
REQ-005 SHALL have port: flush_i  input  1  branch/exception redirect; discard everything in flight.
REQ-006 SHALL have port: stall_i  input  1  decode not accepting this cycle.
REQ-007 SHALL have ports: imem_req_o out 1, imem_addr_o out 32, imem_gnt_i in 1, imem_rvalid_i in 1, imem_rdata_i in 32  instruction-memory request/grant plus response.
REQ-008 SHALL have ports: if_valid_o out 1, if_pc_o out 32, if_inst_o out 32, if_exc_o out 1  IF/ID register; if_exc_o flags address-error-on-fetch.

Function
REQ-009 SHALL implement FSM states S_REQ, S_WAIT, S_DROP; combinational outputs decode registered state.
REQ-010 Output slot "free" SHALL mean (!if_valid_o || !stall_i); a slot is consumed when if_valid_o && !stall_i.
REQ-011 S_REQ, pc_i[1:0]==0, slot free, !flush_i: imem_req_o=1, imem_addr_o=pc_i.
REQ-012 S_REQ, grant (req && imem_gnt_i): pc_en_o=1 same cycle; pc_i latched into req_pc; next state S_WAIT (S_DROP if flush_i same cycle).
REQ-013 pc_en_o SHALL be 0 in all other cycles except REQ-018.
REQ-014 S_WAIT, imem_rvalid_i, !flush_i: next cycle if_valid_o=1, if_pc_o=req_pc, if_inst_o=imem_rdata_i, if_exc_o=0; next state S_REQ.
REQ-015 S_WAIT, flush_i without rvalid: next state S_DROP; flush_i with rvalid same cycle: data discarded, next state S_REQ.
REQ-016 S_DROP: imem_req_o=0; on imem_rvalid_i discard data, next state S_REQ; flush_i in S_DROP keeps S_DROP.
REQ-017 Exactly one outstanding request max; no new req while in S_WAIT/S_DROP.
REQ-018 S_REQ, pc_i[1:0]!=0, slot free, !flush_i: no memory request; pc_en_o=1; next cycle if_valid_o=1, if_pc_o=pc_i, if_inst_o=0, if_exc_o=1; state stays S_REQ.
REQ-019 IF/ID register SHALL hold all values while if_valid_o && stall_i.
REQ-020 Consumed without reload SHALL clear if_valid_o next cycle; if_pc_o/if_inst_o may hold stale values.
REQ-021 flush_i SHALL clear if_valid_o and if_exc_o next cycle regardless of stall_i, and suppress any load that cycle.
REQ-022 flush_i in S_REQ SHALL suppress imem_req_o and pc_en_o that cycle; state stays S_REQ.
REQ-023 Throughput SHALL be one instruction per two cycles at best (grant cycle, response cycle) with zero-wait memory.

Reset
REQ-024 While rst=1: state<=S_REQ, if_valid_o<=0, if_exc_o<=0, if_pc_o<=0, if_inst_o<=0, req_pc<=0; imem_req_o=0, pc_en_o=0 combinationally.
REQ-025 Reset mid-request (S_WAIT/S_DROP) SHALL abandon the outstanding response; memory is reset together with this block.
REQ-026 First request SHALL issue on the first cycle with rst=0.

Verification
REQ-027 Reset release, pc_i=0xBFC00000, gnt=1 immediately, rvalid next cycle with rdata=0x24080001 -> req at cycle 0, pc_en_o=1 at cycle 0, if_valid_o=1, if_pc_o=0xBFC00000, if_inst_o=0x24080001 at cycle 2.
REQ-028 gnt withheld 3 cycles -> imem_req_o held 1 with stable imem_addr_o, pc_en_o=0 until grant cycle.
REQ-029 if_valid_o=1, stall_i=1 for 4 cycles -> no new request, outputs stable; stall_i=0 -> next request issued same cycle.
REQ-030 flush_i in S_WAIT, rvalid 2 cycles later with 0xDEADBEEF -> data never appears on if_inst_o; next request after the dropped response.
REQ-031 pc_i=0xBFC00002 in S_REQ -> imem_req_o=0, pc_en_o=1, next cycle if_valid_o=1, if_exc_o=1, if_pc_o=0xBFC00002, if_inst_o=0.
REQ-032 rst asserted in S_WAIT -> next cycle if_valid_o=0, state S_REQ, stale rvalid before rst deassert ignored.
